// File: rtl/mem_mode_ctrl.sv
// rtl/mem_mode_ctrl.sv - switch-driven ROM/RAM read/write/increment sequencer for the 7-seg display
// Optional INC_SAT_EN: increment saturates at all-ones instead of wrapping.
module mem_mode_ctrl #(
  parameter int AW = 10,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [15:0]   disp_word,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_CAP  = 3'd2,
    WR      = 3'd3,
    INC_WR  = 3'd4,
    DONE    = 3'd5
  } state_t;

`ifdef INC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t        state, state_nxt;
  logic [1:0]    mode_l;
  logic [AW-1:0] addr_l;
  logic [DW-1:0] din_l;
  logic [DW-1:0] a_q, b_q;
  logic          inc_done;
  logic          we_nxt;
  logic [DW-1:0] din_nxt;
  logic          new_cmd;
  logic          skip_cap, skip_inc;

  // Only a change of the full switch setting starts a command, so a held setting runs once.
  assign new_cmd  = (state == IDLE) && ({mode, addr, din} != {mode_l, addr_l, din_l});
  assign skip_cap = SAT_EN && (&ram_dout);
  assign skip_inc = SAT_EN && (&b_q);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign disp_word = {2'b00, mode_l, addr_l[3:0], a_q, b_q};

  always_comb begin
    state_nxt = state;
    we_nxt    = 1'b0;
    din_nxt   = ram_din;
    case (state)
      IDLE: begin
        if (new_cmd) begin
          case (mode)
            2'b00:   state_nxt = DONE;
            2'b10: begin
              state_nxt = WR;
              we_nxt    = 1'b1;
              din_nxt   = din;
            end
            default: state_nxt = RD_WAIT;
          endcase
        end
      end
      WR:      state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RD_CAP;
      RD_CAP: begin
        if (mode_l == 2'b11 && !inc_done) begin
          // The write pulse is registered, so it is launched here and is high during INC_WR.
          state_nxt = INC_WR;
          we_nxt    = !skip_cap;
          din_nxt   = DW'(ram_dout + 1'b1);
        end else begin
          state_nxt = DONE;
        end
      end
      INC_WR:  state_nxt = skip_inc ? DONE : RD_WAIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_l   <= '0;
      addr_l   <= '0;
      din_l    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      inc_done <= 1'b0;
      rom_addr <= '0;
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_din  <= '0;
    end else begin
      state   <= state_nxt;
      ram_we  <= we_nxt;
      ram_din <= din_nxt;
      if (new_cmd) begin
        mode_l   <= mode;
        addr_l   <= addr;
        din_l    <= din;
        rom_addr <= addr;
        ram_addr <= addr;
        inc_done <= 1'b0;
      end
      if (new_cmd && mode == 2'b00) begin
        a_q <= '0;
        b_q <= '0;
      end else if (state == RD_CAP) begin
        a_q <= rom_dout;
        b_q <= ram_dout;
      end
      if (state == INC_WR) inc_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_mode_ctrl.sv
// tb/tb_mem_mode_ctrl.sv - randomized bench for mem_mode_ctrl against a command-level reference model
module tb_mem_mode_ctrl;
  localparam int AW = 10;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [AW-1:0] rom_addr, ram_addr;
  logic [DW-1:0] rom_dout, ram_dout, ram_din;
  logic          ram_we;
  logic [15:0]   disp_word;
  logic          busy, done;

  always #5 clk = ~clk;

  mem_mode_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .addr(addr), .din(din),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .disp_word(disp_word), .busy(busy), .done(done)
  );

  // ROM A[] and RAM B[] as the datapath sees them: sync read, 1-cycle latency, read-first RAM
  logic [DW-1:0] mem_a [0:1023];
  logic [DW-1:0] mem_b [0:1023] = '{default: '0};

  always @(posedge clk) begin
    if (ram_we) mem_b[ram_addr] <= ram_din;
    ram_dout <= mem_b[ram_addr];
    rom_dout <= mem_a[rom_addr];
  end

  // Reference model state: expected RAM contents and the last executed command
  int            ref_b [0:1023];
  logic [1:0]    lm;
  logic [AW-1:0] la;
  logic [DW-1:0] ld;
  int            exp_lat, exp_nwr, exp_wdata;
  logic [AW-1:0] exp_waddr;
  logic [15:0]   exp_disp;
  bit            noexec;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic predict(input logic [1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] ma, mb;
    noexec = ({m, a, d} == {lm, la, ld});
    if (noexec) return;
    lm = m; la = a; ld = d;
    exp_waddr = a;
    exp_wdata = 0;
    ma = mem_a[a];
    case (m)
      2'b00: begin ma = 0; mb = 0; exp_lat = 1; exp_nwr = 0; end
      2'b01: begin mb = DW'(ref_b[a]); exp_lat = 3; exp_nwr = 0; end
      2'b10: begin ref_b[a] = d; mb = d; exp_lat = 4; exp_nwr = 1; exp_wdata = d; end
      default: begin
`ifdef INC_SAT_EN
        if (ref_b[a] == 15) begin
          mb = 4'hF; exp_lat = 4; exp_nwr = 0;
        end else begin
          ref_b[a] = ref_b[a] + 1; mb = DW'(ref_b[a]); exp_lat = 6; exp_nwr = 1; exp_wdata = ref_b[a];
        end
`else
        ref_b[a] = (ref_b[a] + 1) % 16; mb = DW'(ref_b[a]); exp_lat = 6; exp_nwr = 1; exp_wdata = ref_b[a];
`endif
      end
    endcase
    exp_disp = {2'b00, m, a[3:0], ma, mb};
  endtask

  task automatic measure(input bit chg, input logic [1:0] m2, input logic [AW-1:0] a2,
                         input logic [DW-1:0] d2);
    int cyc = 0;
    int nwr = 0;
    bit seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (chg && cyc == 1) begin mode = m2; addr = a2; din = d2; end
      if (ram_we) begin
        nwr++;
        chk("wr_addr", 32'(ram_addr), 32'(exp_waddr));
        chk("wr_data", 32'(ram_din), 32'(exp_wdata));
      end
      if (done) seen = 1;
      else chk("busy_during_cmd", 32'(busy), 32'd1);
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("write_count", 32'(nwr), 32'(exp_nwr));
    chk("disp_word", 32'(disp_word), 32'(exp_disp));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("we_after_done", 32'(ram_we), 32'd0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_we", 32'(ram_we), 32'd0);
    end
  endtask

  task automatic run(input logic [1:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mode = m; addr = a; din = d;
    predict(m, a, d);
    if (noexec) idle_check(4);
    else measure(0, 2'b00, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_din"}, 32'(ram_din), 32'd0);
    chk({tag, "_disp"}, 32'(disp_word), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [1:0]    rm;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [DW-1:0] b10_before;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = DW'($urandom);
      ref_b[i] = 0;
    end
    lm = 0; la = 0; ld = 0;
    rst = 1; mode = 0; addr = 0; din = 0;
    @(posedge clk); #1;
    rst = 0;
    check_reset_outputs("reset");
    idle_check(2);

    // Directed write, read, held increment, re-entered increment
    run(2'b10, 10'd5, 4'd7);
    run(2'b01, 10'd5, 4'd7);
    run(2'b11, 10'd5, 4'd7);
    idle_check(200);
    run(2'b01, 10'd5, 4'd7);
    run(2'b11, 10'd5, 4'd7);

    // Increment of an all-ones cell
    run(2'b10, 10'd10, 4'hF);
    run(2'b11, 10'd10, 4'hF);
    run(2'b00, 10'd3, 4'd0);

    // Inputs changed while busy run once after the current command finishes
    mode = 2'b01; addr = 10'd20; din = 4'd0;
    predict(2'b01, 10'd20, 4'd0);
    measure(1, 2'b10, 10'd21, 4'd4);
    predict(2'b10, 10'd21, 4'd4);
    measure(0, 2'b00, '0, '0);
    idle_check(3);

    // Randomized commands, with occasional repeats that must not execute
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        rm = lm; ra = la; rd = ld;
      end else begin
        rm = 2'($urandom_range(0, 3));
        ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        rd = DW'($urandom);
      end
      run(rm, ra, rd);
    end
    for (int i = 0; i < 16; i++) chk("ram_contents", 32'(mem_b[i]), 32'(ref_b[i]));

    // Reset on the edge that would enter WR: nothing is written
    b10_before = mem_b[10];
    rst = 1; mode = 2'b10; addr = 10'd10; din = DW'(b10_before + 4'd3);
    @(posedge clk); #1;
    check_reset_outputs("rst_at_wr");
    mode = 0; addr = 0; din = 0;
    @(posedge clk); #1;
    rst = 0;
    lm = 0; la = 0; ld = 0;
    idle_check(6);
    chk("rst_b10_unchanged", 32'(mem_b[10]), 32'(b10_before));

    // Reset in the middle of a read
    mode = 2'b01; addr = 10'd7; din = 0;
    @(posedge clk); #1;
    chk("midop_busy", 32'(busy), 32'd1);
    rst = 1; mode = 0; addr = 0;
    @(posedge clk); #1;
    rst = 0;
    check_reset_outputs("rst_midop");
    idle_check(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
